// File: rtl/vmem_pkg.sv
// Shared types and widths for the stage-2 virtual memory map loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vmem_pkg;

  localparam int MAP_ADR_W  = 10;
  localparam int MAP_DATA_W = 24;
  localparam int VMAP_W     = 5;
  localparam int MAPI_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WR,
    ST_RD,
    ST_RDW,
    ST_RESP
  } state_e;

endpackage

// File: rtl/vmem1_fill_ctr.sv
// Fill index counter: synchronous clear, grant-gated increment, terminal flag.
// Latency: count updates at the clock edge after an enabled, granted cycle.
// Backpressure: holds while grant_i=0; saturates at the terminal index, never wraps.
// Ports: clk/reset (sync, active-low), clr_i, en_i, grant_i -> cnt_o, term_o.
module vmem1_fill_ctr
  import vmem_pkg::*;
#(
  parameter int MAP_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 grant_i,
  output logic [MAP_ADR_W-1:0] cnt_o,
  output logic                 term_o
);

  localparam logic [MAP_ADR_W-1:0] TERM = MAP_ADR_W'(MAP_DEPTH - 1);

  logic [MAP_ADR_W-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == TERM);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && grant_i && !term_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vmem1_loader.sv
// Host writer/reader and power-up filler for the 1024x24 stage-2 map RAM.
// Latency: map_grant is sampled at the edge; the registered pulse shows the next cycle
//   (write pulse 1 cycle after accept, rsp_valid 2 cycles after the read pulse).
// Backpressure: cmd_ready low while filling/busy/response pending; rsp held until rsp_ready.
// Ports: host cmd_* / rsp_* handshakes, init_start/init_done/busy status,
//   map side vmap_o/mapi_o (address), vma_o (data), vm1rp_o/vm1wp_o (pulses), vmo_i (read data).
module vmem1_loader
  import vmem_pkg::*;
#(
  parameter logic [MAP_DATA_W-1:0] INIT_VALUE = 24'h000000,
  parameter bit                    AUTO_INIT  = 1'b1,
  parameter int                    MAP_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  map_grant,
  input  logic                  init_start,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [MAP_ADR_W-1:0]  cmd_adr,
  input  logic [MAP_DATA_W-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MAP_DATA_W-1:0] rsp_data,
  output logic                  busy,
  output logic                  init_done,
  output logic [VMAP_W-1:0]     vmap_o,
  output logic [MAPI_W-1:0]     mapi_o,
  output logic [MAP_DATA_W-1:0] vma_o,
  output logic                  vm1rp_o,
  output logic                  vm1wp_o,
  input  logic [MAP_DATA_W-1:0] vmo_i
);

  state_e                state_q, state_d;
  logic [VMAP_W-1:0]     vmap_q, vmap_d;
  logic [MAPI_W-1:0]     mapi_q, mapi_d;
  logic [MAP_DATA_W-1:0] vma_q, vma_d;
  logic                  rp_q, rp_d;
  logic                  wp_q, wp_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [MAP_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                  init_done_q, init_done_d;

  logic                  ctr_clr, ctr_en, ctr_term;
  logic [MAP_ADR_W-1:0]  ctr_cnt;

  vmem1_fill_ctr #(
    .MAP_DEPTH(MAP_DEPTH)
  ) u_fill_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (ctr_clr),
    .en_i   (ctr_en),
    .grant_i(map_grant),
    .cnt_o  (ctr_cnt),
    .term_o (ctr_term)
  );

  // init_start wins over a same-cycle command, so ready drops with it.
  assign cmd_ready = (state_q == ST_IDLE) && init_done_q && !rsp_valid_q && !init_start;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    vmap_d      = vmap_q;
    mapi_d      = mapi_q;
    vma_d       = vma_q;
    rp_d        = 1'b0;
    wp_d        = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    init_done_d = init_done_q;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (init_start) begin
          state_d     = ST_FILL;
          ctr_clr     = 1'b1;
          init_done_d = 1'b0;
        end else if (cmd_valid && cmd_ready) begin
          // Address (and write data) load at accept; the pulse follows once granted.
          {vmap_d, mapi_d} = cmd_adr;
          if (cmd_write) begin
            vma_d   = cmd_data;
            wp_d    = map_grant;
            state_d = ST_WR;
          end else begin
            rp_d    = map_grant;
            state_d = ST_RD;
          end
        end
      end

      ST_FILL: begin
        // The counter saturates at the last index; finish once that index's pulse is out.
        if (ctr_term && wp_q && ({vmap_q, mapi_q} == ctr_cnt)) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          ctr_en = 1'b1;
          if (map_grant) begin
            wp_d             = 1'b1;
            {vmap_d, mapi_d} = ctr_cnt;
            vma_d            = INIT_VALUE;
          end
        end
      end

      ST_WR: begin
        if (wp_q) begin
          state_d = ST_IDLE;
        end else begin
          wp_d = map_grant;
        end
      end

      ST_RD: begin
        if (rp_q) begin
          state_d = ST_RDW;
        end else begin
          rp_d = map_grant;
        end
      end

      // Map read data is valid the cycle after the pulse.
      ST_RDW: begin
        rsp_data_d  = vmo_i;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= AUTO_INIT ? ST_FILL : ST_IDLE;
      vmap_q      <= '0;
      mapi_q      <= '0;
      vma_q       <= '0;
      rp_q        <= 1'b0;
      wp_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vmap_q      <= vmap_d;
      mapi_q      <= mapi_d;
      vma_q       <= vma_d;
      rp_q        <= rp_d;
      wp_q        <= wp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign vmap_o    = vmap_q;
  assign mapi_o    = mapi_q;
  assign vma_o     = vma_q;
  assign vm1rp_o   = rp_q;
  assign vm1wp_o   = wp_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_vmem1_loader.sv
// Directed bench for vmem1_loader with a behavioural map RAM and a read scoreboard.
module tb_vmem1_loader;

  logic        clk = 1'b0;
  logic        reset, map_grant, init_start;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_adr;
  logic [23:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [23:0] rsp_data;
  logic        busy, init_done;
  logic [4:0]  vmap_o, mapi_o;
  logic [23:0] vma_o;
  logic        vm1rp_o, vm1wp_o;
  logic [23:0] vmo_i;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  logic g_prev = 1'b0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  vmem1_loader dut (
    .clk       (clk),
    .reset     (reset),
    .map_grant (map_grant),
    .init_start(init_start),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_adr   (cmd_adr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .init_done (init_done),
    .vmap_o    (vmap_o),
    .mapi_o    (mapi_o),
    .vma_o     (vma_o),
    .vm1rp_o   (vm1rp_o),
    .vm1wp_o   (vm1wp_o),
    .vmo_i     (vmo_i)
  );

  // Map RAM model; never-written words return a non-zero pattern so the fill is visible.
  logic [23:0] mem  [0:1023];
  logic        seen [0:1023];
  wire  [9:0]  ma = {vmap_o, mapi_o};

  always @(posedge clk) begin
    if (vm1wp_o) begin
      mem[ma]  <= vma_o;
      seen[ma] <= 1'b1;
    end
    if (vm1rp_o) vmo_i <= (seen[ma] === 1'b1) ? mem[ma] : (24'h5A0000 ^ {14'h0, ma});
  end

  always @(posedge clk) g_prev <= map_grant;

  // Pulse exclusivity and grant rule on every cycle once out of reset.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      assert (!(vm1rp_o && vm1wp_o)) else begin
        fails++;
        $error("FAIL pulse_excl: rp=%0b wp=%0b required not both", vm1rp_o, vm1wp_o);
      end
      if (vm1rp_o || vm1wp_o) begin
        tests++;
        assert (g_prev === 1'b1) else begin
          fails++;
          $error("FAIL pulse_grant: grant before pulse=%0b required 1", g_prev);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {1'b0, cmd_ready, rsp_valid, rsp_data, init_done, vm1rp_o, vm1wp_o,
            vmap_o, mapi_o, vma_o};
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk(tag, cmd_ready, 1);
  endtask

  task automatic do_write(input logic [9:0] adr, input logic [23:0] dat);
    wait_ready("wr_rdy");
    cmd_valid = 1; cmd_write = 1; cmd_adr = adr; cmd_data = dat;
    tick();
    cmd_valid = 0; cmd_write = 0;
    chk("wr_pulse", vm1wp_o, 1);
    chk("wr_vmap", vmap_o, adr[9:5]);
    chk("wr_mapi", mapi_o, adr[4:0]);
    chk("wr_data", vma_o, dat);
    tick();
    chk("wr_pulse_1cyc", vm1wp_o, 0);
  endtask

  task automatic do_read(input logic [9:0] adr, input logic [23:0] expv, input int hold);
    int n = 0;
    logic [23:0] snap;
    wait_ready("rd_rdy");
    cmd_valid = 1; cmd_write = 0; cmd_adr = adr;
    exp_q.push_back(expv);
    tick();
    cmd_valid = 0;
    chk("rd_pulse", vm1rp_o, 1);
    chk("rd_adr", {vmap_o, mapi_o}, adr);
    rsp_ready = (hold == 0);
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rd_lat", n, 2);
    if (hold > 0) begin
      snap = rsp_data;
      cmd_valid = 1; cmd_write = 0; cmd_adr = adr;
      for (int k = 0; k < hold; k++) begin
        tick();
        chk("hold_vld", rsp_valid, 1);
        chk("hold_dat", rsp_data, snap);
        chk("hold_nordy", cmd_ready, 0);
        chk("hold_nopulse", vm1rp_o, 0);
      end
      rsp_ready = 1;
    end
    if (exp_q.size() > 0) chk("rd_data", rsp_data, exp_q.pop_front());
    else chk("sb_underflow", exp_q.size(), 1);
    tick();
    rsp_ready = 0;
    chk("rsp_clr", rsp_valid, 0);
  endtask

  task automatic run_fill(input bit toggle, input string tag);
    int pulses = 0, nxt = 0, cyc = 0, last_at = -100;
    bit order_ok = 1, rsp_seen = 0;
    while (!init_done && cyc < 4000) begin
      if (toggle) map_grant = ((cyc % 4) >= 2);
      tick();
      cyc++;
      if (vm1wp_o) begin
        if ({vmap_o, mapi_o} != 10'(nxt) || vma_o != 24'h000000) order_ok = 0;
        pulses++;
        nxt++;
        last_at = cyc;
      end
      if (rsp_valid) rsp_seen = 1;
    end
    map_grant = 1;
    chk({tag, "_bound"}, (cyc < 4000), 1);
    chk({tag, "_pulses"}, pulses, 1024);
    chk({tag, "_order"}, order_ok, 1);
    chk({tag, "_done_lat"}, cyc - last_at, 1);
    chk({tag, "_no_rsp"}, rsp_seen, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int n;
    reset = 0; map_grant = 1; init_start = 0; cmd_valid = 0; cmd_write = 0;
    cmd_adr = '0; cmd_data = '0; rsp_ready = 0;

    repeat (3) tick();
    chk("rst_outs", outs(), 64'h0);
    chk("rst_busy_fill", busy, 1);
    mon_en = 1;

    // Auto fill after reset release, then the whole map reads back as zero.
    reset = 1;
    run_fill(0, "fill0");
    for (int i = 0; i < 1024; i++) do_read(10'(i), 24'h000000, 0);

    // Directed write/read pair.
    do_write(10'h2A5, 24'hABCDEF);
    chk("wr_vmap_const", vmap_o, 5'h15);
    chk("wr_mapi_const", mapi_o, 5'h05);
    do_read(10'h2A5, 24'hABCDEF, 0);

    // Write accepted with grant low stalls with address held and pulse low.
    wait_ready("wst_rdy");
    map_grant = 0; cmd_valid = 1; cmd_write = 1; cmd_adr = 10'h01F; cmd_data = 24'h123456;
    tick();
    cmd_valid = 0; cmd_write = 0;
    chk("wst_nopulse0", vm1wp_o, 0);
    tick();
    chk("wst_nopulse1", vm1wp_o, 0);
    chk("wst_adr_held", {vmap_o, mapi_o}, 10'h01F);
    map_grant = 1;
    tick();
    chk("wst_pulse", vm1wp_o, 1);
    chk("wst_data", vma_o, 24'h123456);
    tick();
    chk("wst_done", busy, 0);
    do_read(10'h01F, 24'h123456, 0);

    // Response held 5 cycles; a waiting command only goes in after the handshake.
    do_read(10'h2A5, 24'hABCDEF, 5);
    do_read(10'h2A5, 24'hABCDEF, 0);

    // init_start and cmd_valid together: fill wins, command is dropped.
    init_start = 1; cmd_valid = 1; cmd_write = 0; cmd_adr = 10'h2A5;
    #1;
    chk("pri_nordy", cmd_ready, 0);
    tick();
    init_start = 0; cmd_valid = 0;
    chk("pri_fill", busy, 1);
    chk("pri_done_clr", init_done, 0);
    chk("pri_norp", vm1rp_o, 0);
    run_fill(0, "fill_pri");
    chk("sb_after_pri", exp_q.size(), 0);

    // Fill with grant toggling every other cycle.
    init_start = 1;
    tick();
    init_start = 0;
    run_fill(1, "fill_tog");
    do_read(10'h2A5, 24'h000000, 0);

    // Reset in the middle of a fill.
    init_start = 1;
    tick();
    init_start = 0;
    n = 0;
    while (!(vm1wp_o && {vmap_o, mapi_o} == 10'd500) && n < 2000) begin
      tick();
      n++;
    end
    chk("mid_reach", {vm1wp_o, vmap_o, mapi_o}, {1'b1, 10'd500});
    reset = 0;
    tick();
    chk("mid_rst_outs", outs(), 64'h0);
    reset = 1;
    run_fill(0, "refill");
    do_read(10'h3FF, 24'h000000, 0);
    do_read(10'h000, 24'h000000, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
